adc_conv_sequencer: RTL and testbench

- Generates the conversion-control inputs of the ADC parallel-interface controller: `PD_in` (power-up) and `CONVST_in` (conversion start), at a fixed sample rate.
- Monitors `EOC_18` so that no new conversion starts while the controller's 16-cycle read window is still running.
- Flags conversions that never complete and sample periods that overrun.
- Sits directly upstream of the ADC controller, in the same `clk_100M` domain.

---
 rtl/adc_pkg.sv | 30 +++
 rtl/eoc_sync.sv | 27 ++
 rtl/adc_conv_sequencer.sv | 133 +++++++++++++
 tb/tb_adc_conv_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
package adc_pkg;

   localparam int CNT_W = 16;

   localparam int DEF_PWRUP_CYCLES      = 100000;
   localparam int DEF_CONVST_LOW_CYCLES = 4;
   localparam int DEF_SAMPLE_PERIOD     = 100;
   localparam int DEF_EOC_TIMEOUT       = 50;
   localparam int DEF_READ_GUARD        = 16;

   typedef enum logic [2:0] {
      OFF,
      PWRUP,
      IDLE,
      CONV,
      WAIT_EOC,
      GUARD,
      HOLD
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/eoc_sync.sv
// Two-flop synchronizer for the asynchronous EOC_18 pin plus a registered
// falling-edge detector producing a single-cycle eoc_fall pulse.
module eoc_sync (
   input  logic clk_100M,
   input  logic Reset,
   input  logic eoc_n,
   output logic eoc_fall
);

   logic [1:0] sync_q;
   logic       eoc_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         sync_q   <= 2'b11;
         eoc_prev <= 1'b1;
         eoc_fall <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], eoc_n};
         eoc_prev <= sync_q[1];
         eoc_fall <= eoc_prev & ~sync_q[1];
      end
   end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Conversion-control sequencer for the ADC parallel-interface controller:
// drives PD_in/CONVST_in at a fixed sample rate and flags timeouts and overruns.
module adc_conv_sequencer
   import adc_pkg::*;
#(
   parameter int PWRUP_CYCLES      = DEF_PWRUP_CYCLES,
   parameter int CONVST_LOW_CYCLES = DEF_CONVST_LOW_CYCLES,
   parameter int SAMPLE_PERIOD     = DEF_SAMPLE_PERIOD,
   parameter int EOC_TIMEOUT       = DEF_EOC_TIMEOUT,
   parameter int READ_GUARD        = DEF_READ_GUARD
) (
   input  logic             clk_100M,
   input  logic             Reset,
   input  logic             enable,
   input  logic             power_down,
   input  logic             err_clr,
   input  logic             EOC_18,
   output logic             CONVST_in,
   output logic             PD_in,
   output logic             busy,
   output logic             sample_tick,
   output logic [CNT_W-1:0] conv_count,
   output logic             timeout_err,
   output logic             overrun_err
);

   localparam int PH_MAX = max_int(max_int(PWRUP_CYCLES, CONVST_LOW_CYCLES),
                                   max_int(EOC_TIMEOUT, READ_GUARD));
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0]  PWRUP_LAST  = PH_W'(PWRUP_CYCLES - 1);
   localparam logic [PH_W-1:0]  LOW_LAST    = PH_W'(CONVST_LOW_CYCLES - 1);
   localparam logic [PH_W-1:0]  TO_LAST     = PH_W'(EOC_TIMEOUT - 1);
   localparam logic [PH_W-1:0]  GUARD_LAST  = PH_W'(READ_GUARD - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);

   seq_state_t       state;
   seq_state_t       next_state;
   logic [PH_W-1:0]  phase_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             eoc_fall;
   logic             conv_done;
   logic             to_hit;
   logic             ov_hit;
   logic             period_done;

   eoc_sync u_eoc_sync (
      .clk_100M (clk_100M),
      .Reset    (Reset),
      .eoc_n    (EOC_18),
      .eoc_fall (eoc_fall)
   );

   assign period_done = (period_cnt >= PERIOD_LAST);

   // NOTE: every signal driven here gets a default before the case, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      conv_done  = 1'b0;
      to_hit     = 1'b0;
      ov_hit     = 1'b0;
      case (state)
         OFF: begin
            if (enable) next_state = PWRUP;
         end
         PWRUP: begin
            if (phase_cnt == PWRUP_LAST) next_state = IDLE;
         end
         IDLE: begin
            if (enable)          next_state = CONV;
            else if (power_down) next_state = OFF;
         end
         CONV: begin
            if (phase_cnt == LOW_LAST) next_state = WAIT_EOC;
         end
         WAIT_EOC: begin
            if (eoc_fall) begin
               conv_done  = 1'b1;
               next_state = GUARD;
            end else if (phase_cnt == TO_LAST) begin
               to_hit     = 1'b1;
               next_state = HOLD;
            end
         end
         GUARD: begin
            if (phase_cnt == GUARD_LAST) next_state = HOLD;
         end
         HOLD: begin
            // phase_cnt is zero only in the first HOLD cycle (it saturates)
            ov_hit = (phase_cnt == '0) && period_done;
            if (period_done) next_state = enable ? CONV : IDLE;
         end
         default: next_state = OFF;
      endcase
   end

   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         state      <= OFF;
         phase_cnt  <= '0;
         period_cnt <= '0;
      end else begin
         state <= next_state;
         if (next_state != state) phase_cnt <= '0;
         else if (!(&phase_cnt))  phase_cnt <= phase_cnt + 1'b1;
         if (next_state == CONV && state != CONV) period_cnt <= '0;
         else                                     period_cnt <= sat_inc16(period_cnt);
      end
   end

   // Outputs are registered from next_state so they line up with the state.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         CONVST_in   <= 1'b1;
         PD_in       <= 1'b0;
         busy        <= 1'b0;
         sample_tick <= 1'b0;
         conv_count  <= '0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         CONVST_in   <= (next_state != CONV);
         PD_in       <= (next_state != OFF);
         busy        <= (next_state inside {CONV, WAIT_EOC, GUARD});
         sample_tick <= conv_done;
         if (conv_done) conv_count <= conv_count + 1'b1;
         timeout_err <= to_hit | (timeout_err & ~err_clr);
         overrun_err <= ov_hit | (overrun_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Randomized self-checking bench: a timestamp-level model predicts when each
// conversion starts, ticks, times out or overruns, and the DUT is compared to it.
module tb_adc_conv_sequencer;

   localparam int L  = 4;
   localparam int T  = 50;
   localparam int G  = 16;
   localparam int PW = 10;

   logic clk_100M = 1'b0;
   logic Reset, enable, power_down, err_clr, eoc_18, sel;
   logic en_a, en_b;

   logic        convst_a, pd_a, busy_a, tick_a, to_a, ov_a;
   logic        convst_b, pd_b, busy_b, tick_b, to_b, ov_b;
   logic [15:0] count_a, count_b;

   logic        o_convst, o_pd, o_busy, o_tick, o_to, o_ov;
   logic [15:0] o_count;

   int   cyc = 0;
   int   n_checks, n_pass;
   int   m_period;
   logic [15:0] m_count;
   bit   exp_to, exp_ov;

   assign en_a = enable & ~sel;
   assign en_b = enable & sel;

   assign o_convst = sel ? convst_b : convst_a;
   assign o_pd     = sel ? pd_b     : pd_a;
   assign o_busy   = sel ? busy_b   : busy_a;
   assign o_tick   = sel ? tick_b   : tick_a;
   assign o_to     = sel ? to_b     : to_a;
   assign o_ov     = sel ? ov_b     : ov_a;
   assign o_count  = sel ? count_b  : count_a;

   adc_conv_sequencer #(.PWRUP_CYCLES(PW)) dut_a (
      .clk_100M    (clk_100M),
      .Reset       (Reset),
      .enable      (en_a),
      .power_down  (power_down),
      .err_clr     (err_clr),
      .EOC_18      (eoc_18),
      .CONVST_in   (convst_a),
      .PD_in       (pd_a),
      .busy        (busy_a),
      .sample_tick (tick_a),
      .conv_count  (count_a),
      .timeout_err (to_a),
      .overrun_err (ov_a)
   );

   adc_conv_sequencer #(.PWRUP_CYCLES(PW), .SAMPLE_PERIOD(30)) dut_b (
      .clk_100M    (clk_100M),
      .Reset       (Reset),
      .enable      (en_b),
      .power_down  (power_down),
      .err_clr     (err_clr),
      .EOC_18      (eoc_18),
      .CONVST_in   (convst_b),
      .PD_in       (pd_b),
      .busy        (busy_b),
      .sample_tick (tick_b),
      .conv_count  (count_b),
      .timeout_err (to_b),
      .overrun_err (ov_b)
   );

   initial forever #5 clk_100M = ~clk_100M;

   always @(posedge clk_100M) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      else n_pass++;
   endtask

   // One conversion: eoc_dly < 0 means EOC never falls.
   task automatic run_conv(input int eoc_dly, input bit drop_en, input int exp_fall,
                           output int next_fall);
      int fall_t, rise_t, tick_t, ticks, bfall_t, to_t, r, hold, exp_tick;
      bit got, to_was;
      got = 1'b0; rise_t = -1; tick_t = -1; ticks = 0; bfall_t = -1; to_t = -1;
      next_fall = -1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk_100M);
         err_clr = 1'b0;
         if (!o_convst) got = 1'b1;
      end
      if (!got) begin
         check("conv_start_seen", 0, 1);
         return;
      end
      fall_t = cyc;
      check("convst_fall_cycle", fall_t, exp_fall);
      check("busy_at_fall", o_busy, 1);
      check("overrun_at_fall", o_ov, exp_ov);
      to_was = o_to;
      r        = fall_t + L;
      exp_tick = (eoc_dly >= 0 && eoc_dly + 3 < T) ? r + eoc_dly + 4 : -1;
      hold     = (exp_tick >= 0) ? exp_tick + G : r + T;
      while (cyc < hold) begin
         @(negedge clk_100M);
         if (o_convst && rise_t < 0) rise_t = cyc;
         if (o_tick) begin
            ticks++;
            tick_t = cyc;
         end
         if (!o_busy && bfall_t < 0) bfall_t = cyc;
         if (o_to && !to_was && to_t < 0) to_t = cyc;
         if (drop_en && cyc == r + 2) enable = 1'b0;
         if (eoc_dly >= 0 && cyc == r + eoc_dly) eoc_18 = 1'b0;
         if (eoc_dly >= 0 && cyc == r + eoc_dly + 6) eoc_18 = 1'b1;
      end
      eoc_18 = 1'b1;
      check("convst_low_width", rise_t - fall_t, L);
      check("tick_count", ticks, (exp_tick >= 0) ? 1 : 0);
      if (exp_tick >= 0) begin
         check("tick_cycle", tick_t, exp_tick);
         m_count = m_count + 16'd1;
      end else begin
         exp_to = 1'b1;
         if (!to_was) check("timeout_cycle", to_t, r + T);
      end
      check("busy_fall_cycle", bfall_t, hold);
      check("conv_count", o_count, m_count);
      check("timeout_flag", o_to, exp_to);
      check("overrun_flag", o_ov, exp_ov);
      if (hold - fall_t >= m_period - 1) begin
         exp_ov = 1'b1;
         if (enable) next_fall = hold + 1;
      end else if (enable) begin
         next_fall = fall_t + m_period;
      end
   endtask

   initial begin
      int k, nf, bad;
      bit got;
      n_checks = 0; n_pass = 0;
      enable = 1'b0; power_down = 1'b0; err_clr = 1'b0; eoc_18 = 1'b1; sel = 1'b0;
      m_period = 100; m_count = 16'd0; exp_to = 1'b0; exp_ov = 1'b0;
      Reset = 1'b1;
      #1 Reset = 1'b0;
      #2;
      check("rst_convst", o_convst, 1);
      check("rst_pd", o_pd, 0);
      check("rst_busy", o_busy, 0);
      check("rst_tick", o_tick, 0);
      check("rst_count", o_count, 0);
      check("rst_timeout", o_to, 0);
      check("rst_overrun", o_ov, 0);
      repeat (3) @(negedge clk_100M);
      Reset = 1'b1;

      // power-up, with enable wiggled during the count
      @(negedge clk_100M);
      check("pd_before_enable", o_pd, 0);
      enable = 1'b1;
      k = cyc;
      @(negedge clk_100M);
      check("pd_rise", o_pd, 1);
      repeat (2) @(negedge clk_100M);
      enable = 1'b0;
      repeat (3) @(negedge clk_100M);
      enable = 1'b1;
      nf = k + 1 + PW + 1;

      // steady run
      run_conv(20, 1'b0, nf, nf);
      for (int i = 1; i < 10; i++) run_conv(int'($urandom_range(2, 40)), 1'b0, nf, nf);
      check("steady_count", o_count, 10);
      check("steady_timeout_clear", o_to, 0);
      check("steady_overrun_clear", o_ov, 0);

      // timeout, then clear
      run_conv(-1, 1'b0, nf, nf);
      err_clr = 1'b1;
      @(negedge clk_100M);
      err_clr = 1'b0;
      exp_to  = 1'b0;
      check("timeout_cleared", o_to, 0);
      run_conv(int'($urandom_range(2, 40)), 1'b0, nf, nf);

      // counter wrap
      force dut_a.conv_count = 16'hFFFF;
      @(negedge clk_100M);
      release dut_a.conv_count;
      m_count = 16'hFFFF;
      run_conv(int'($urandom_range(2, 40)), 1'b0, nf, nf);

      // disable mid-conversion, then power down
      run_conv(int'($urandom_range(2, 40)), 1'b1, nf, nf);
      bad = 0;
      for (int i = 0; i < 2 * m_period; i++) begin
         @(negedge clk_100M);
         if (!o_convst || o_busy || o_tick) bad++;
      end
      check("idle_after_disable", bad, 0);
      check("pd_in_idle", o_pd, 1);
      power_down = 1'b1;
      @(negedge clk_100M);
      check("pd_after_power_down", o_pd, 0);
      power_down = 1'b0;

      // overrun on the short-period instance
      sel = 1'b1; m_period = 30; m_count = 16'd0; exp_to = 1'b0; exp_ov = 1'b0;
      @(negedge clk_100M);
      enable = 1'b1;
      k = cyc;
      @(negedge clk_100M);
      check("b_pd_rise", o_pd, 1);
      nf = k + 1 + PW + 1;
      run_conv(20, 1'b0, nf, nf);
      err_clr = 1'b1;
      run_conv(20, 1'b0, nf, nf);
      run_conv(int'($urandom_range(2, 40)), 1'b1, nf, nf);
      @(negedge clk_100M);
      check("overrun_sticky_idle", o_ov, 1);
      err_clr = 1'b1;
      @(negedge clk_100M);
      err_clr = 1'b0;
      check("overrun_cleared", o_ov, 0);

      // asynchronous reset while CONVST_in is low
      enable = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk_100M);
         if (!o_convst) got = 1'b1;
      end
      check("async_conv_seen", got, 1);
      #2 Reset = 1'b0;
      #1;
      check("async_convst", o_convst, 1);
      check("async_pd", o_pd, 0);
      check("async_busy", o_busy, 0);
      enable = 1'b0;
      #20 Reset = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
